kbd_ascii_ctrl: RTL
===================

Name: kbd_ascii_ctrl

Overview:
- Sequences the scancode-to-ASCII ROM (four 256x8 tables selected by a 2-bit type: 0 normal, 1 caps, 2 shift, 3 caps+shift).
- Consumes PS/2 scancode bytes from the receiver and tracks modifier state (Shift held, Caps Lock toggled).
- Drives table select and address, waits the ROM latency, then emits one ASCII byte per printable key press.
- Sits between the PS/2 receiver and the display/text-buffer logic.

Parameters:
- ROM_LAT, 0, ROM read latency in clk cycles (0 = combinational ROM; legal values 0..3).
- CNT_W, 8, width of the key-press counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- sc_valid  input  1  scancode byte available
- sc_data  input  8  scancode byte
- sc_ready  output  1  byte accepted when sc_valid && sc_ready
- rom_type  output  2  table select to ROM, = {shift_held, caps_on}
- rom_addr  output  8  ROM address (make code)
- rom_data  input  8  ROM output
- ascii  output  8  last emitted character
- ascii_valid  output  1  one-cycle strobe, ascii is new
- caps_led  output  1  Caps Lock state
- key_cnt  output  CNT_W  count of emitted characters, wraps

Behaviour:
- Reset values: sc_ready=1, rom_type=0, rom_addr=0, ascii=0, ascii_valid=0, caps_led=0, key_cnt=0. Internal shift_l, shift_r, caps_on, prefix flags are all cleared.
- rst is sampled every cycle. Reset mid-lookup aborts with no emit.
- States:
  - IDLE
  - EXT (after E0)
  - BRK (after F0)
  - EXT_BRK (E0 F0)
  - LOOK (ROM_LAT wait)
  - EMIT
- sc_ready=1 only in IDLE/EXT/BRK/EXT_BRK; 0 in LOOK/EMIT.
- IDLE transitions:
  - F0 -> BRK
  - E0 -> EXT
  - 12 -> shift_l=1, stay
  - 59 -> shift_r=1, stay
  - 58 -> caps_on toggles, stay
  - any other byte -> latch into rom_addr, go to LOOK
- BRK: next byte is a release.
  - 12 clears shift_l; 59 clears shift_r.
  - Other codes are ignored.
  - -> IDLE.
- EXT: F0 -> EXT_BRK; any other byte is ignored (extended keys produce no ASCII) -> IDLE.
- EXT_BRK: any byte -> IDLE, no effect.
- shift_held = shift_l | shift_r. rom_type is registered and updates the cycle after the modifier byte is accepted.
- LOOK: rom_type and rom_addr held stable. Wait ROM_LAT cycles (zero wait when ROM_LAT=0), then sample rom_data -> EMIT.
- EMIT, one cycle:
  - If sampled data != 00: ascii <= data, ascii_valid=1, key_cnt+1 (wraps 2^CNT_W-1 -> 0).
  - If sampled data == 00: no strobe, counter unchanged.
  - -> IDLE.
- Latency from accepted make byte to ascii_valid: ROM_LAT+2 cycles.
- Typematic repeats (same make code while held) each emit a character.
- caps_led = caps_on.
- Holding 58 (repeated make codes) toggles caps_on on each repeat; this is suppressed when the filter below is enabled.

Optional Feature:
- Macro: KBD_ASCII_CTRL_REPEAT_FILTER_EN.
- Enabled:
  - Register last_make (reset 00). A make code equal to last_make is dropped: no LOOK, no caps toggle.
  - A break of last_make clears last_make to 00.
  - Modifier codes 12/59 are exempt from the filter.
- Disabled: every make code is processed; there is no last_make register.

Decomposition:
- Package kbd_pkg holds:
  - constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CAPS=8'h58
  - rom_type encodings TYPE_NORM=0, TYPE_CAP=1, TYPE_SHIFT=2, TYPE_CAPSHIFT=3
  - FSM state enum.
- Sub-module kbd_mod_track holds the shift_l/shift_r/caps_on registers and rom_type generation; the FSM stays in the top module.

Test Plan:
- ROM_LAT=1, normal table has 1C->61. Send 1C -> rom_type=0, rom_addr=1C; ascii_valid at accept+3 with ascii=61; key_cnt=1.
- Send 12, 1C, F0 1C, F0 12 with shift table 1C->41 -> one strobe, ascii=41, rom_type=2 during LOOK. After F0 12, rom_type returns to 0.
- Send 58, F0 58, 1C with cap table 1C->41 -> caps_led=1, rom_type=1, ascii=41. Send 58 again -> caps_led=0.
- Send E0 75, E0 F0 75, then 05 mapped to 00 -> no ascii_valid, key_cnt unchanged, sc_ready returns high.
- Assert rst for 1 cycle during LOOK -> no strobe, all outputs at reset values, caps_led=0.
- Send 1C three times without break:
  - filter off -> 3 strobes.
  - KBD_ASCII_CTRL_REPEAT_FILTER_EN on -> 1 strobe; after F0 1C, the next 1C strobes again.

Source files
------------

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared scancode constants, rom_type encodings and FSM state enum
package kbd_pkg;

  // PS/2 set-2 scancodes the controller interprets itself
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // ROM table select encodings
  localparam logic [1:0] TYPE_NORM     = 2'd0;
  localparam logic [1:0] TYPE_CAP      = 2'd1;
  localparam logic [1:0] TYPE_SHIFT    = 2'd2;
  localparam logic [1:0] TYPE_CAPSHIFT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_LOOK,
    ST_EMIT
  } state_t;

  // Maps modifier state onto the ROM table select
  function automatic logic [1:0] rom_type_of(input logic shift_held, input logic caps_on);
    if (shift_held) begin
      rom_type_of = caps_on ? TYPE_CAPSHIFT : TYPE_SHIFT;
    end else begin
      rom_type_of = caps_on ? TYPE_CAP : TYPE_NORM;
    end
  endfunction

endpackage

// File: rtl/kbd_ascii_ctrl_if.sv
// rtl/kbd_ascii_ctrl_if.sv - scancode handshake and ROM lookup bus
interface kbd_ascii_ctrl_if;
  logic       sc_valid;
  logic [7:0] sc_data;
  logic       sc_ready;
  logic [1:0] rom_type;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;

  // master: PS/2 receiver plus ROM side
  modport master (
    output sc_valid, sc_data, rom_data,
    input  sc_ready, rom_type, rom_addr
  );

  // slave: the scancode-to-ASCII controller
  modport slave (
    input  sc_valid, sc_data, rom_data,
    output sc_ready, rom_type, rom_addr
  );
endinterface

// File: rtl/kbd_mod_track.sv
// rtl/kbd_mod_track.sv - shift/caps modifier registers and registered rom_type
module kbd_mod_track
  import kbd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_l,
  input  logic       clr_l,
  input  logic       set_r,
  input  logic       clr_r,
  input  logic       toggle_caps,
  output logic       caps_on,
  output logic [1:0] rom_type
);

  logic shift_l, shift_r;
  logic shift_l_n, shift_r_n, caps_n;

  // next modifier state from the FSM's one-cycle set/clear/toggle pulses
  always_comb begin
    shift_l_n = shift_l;
    shift_r_n = shift_r;
    caps_n    = caps_on ^ toggle_caps;
    if (set_l) shift_l_n = 1'b1;
    if (clr_l) shift_l_n = 1'b0;
    if (set_r) shift_r_n = 1'b1;
    if (clr_r) shift_r_n = 1'b0;
  end

  // modifier registers; rom_type follows in the cycle after the modifier byte
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_l  <= 1'b0;
      shift_r  <= 1'b0;
      caps_on  <= 1'b0;
      rom_type <= TYPE_NORM;
    end else begin
      shift_l  <= shift_l_n;
      shift_r  <= shift_r_n;
      caps_on  <= caps_n;
      rom_type <= rom_type_of(shift_l_n | shift_r_n, caps_n);
    end
  end

endmodule

// File: rtl/kbd_ascii_ctrl.sv
// rtl/kbd_ascii_ctrl.sv - PS/2 scancode to ASCII sequencer; KBD_ASCII_CTRL_REPEAT_FILTER_EN drops typematic repeats
module kbd_ascii_ctrl
  import kbd_pkg::*;
#(
  parameter int ROM_LAT = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  kbd_ascii_ctrl_if.slave  bus,
  output logic [7:0]       ascii,
  output logic             ascii_valid,
  output logic             caps_led,
  output logic [CNT_W-1:0] key_cnt
);

  // LOOK samples rom_data on its final cycle, counted 0..ROM_LAT
  localparam logic [1:0] LOOK_LAST = 2'(ROM_LAT);

  state_t     state, state_n;
  logic [7:0] addr_q, addr_n;
  logic [1:0] wait_q, wait_n;
  logic [7:0] data_q, data_n;
  logic       ready;
  logic       take_make;
  logic       emit;
  logic       set_l, clr_l, set_r, clr_r, tog_caps;
  logic [1:0] type_w;
  logic       caps_w;

`ifdef KBD_ASCII_CTRL_REPEAT_FILTER_EN
  logic [7:0] last_make, last_make_n;
`endif

  assign bus.sc_ready = ready;
  assign bus.rom_addr = addr_q;
  assign bus.rom_type = type_w;
  assign caps_led     = caps_w;

  kbd_mod_track u_mod_track (
    .clk         (clk),
    .rst         (rst),
    .set_l       (set_l),
    .clr_l       (clr_l),
    .set_r       (set_r),
    .clr_r       (clr_r),
    .toggle_caps (tog_caps),
    .caps_on     (caps_w),
    .rom_type    (type_w)
  );

  // next-state, modifier pulses and lookup sequencing
  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    wait_n    = wait_q;
    data_n    = data_q;
    ready     = 1'b0;
    take_make = 1'b0;
    emit      = 1'b0;
    set_l     = 1'b0;
    clr_l     = 1'b0;
    set_r     = 1'b0;
    clr_r     = 1'b0;
    tog_caps  = 1'b0;
`ifdef KBD_ASCII_CTRL_REPEAT_FILTER_EN
    last_make_n = last_make;
`endif
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.sc_valid) begin
          case (bus.sc_data)
            SC_BREAK:  state_n = ST_BRK;
            SC_EXT:    state_n = ST_EXT;
            SC_LSHIFT: set_l = 1'b1;
            SC_RSHIFT: set_r = 1'b1;
            default: begin
`ifdef KBD_ASCII_CTRL_REPEAT_FILTER_EN
              // a repeat of the held key is swallowed, caps included
              if (bus.sc_data != last_make) begin
                last_make_n = bus.sc_data;
                take_make   = 1'b1;
              end
`else
              take_make = 1'b1;
`endif
            end
          endcase
          if (take_make) begin
            if (bus.sc_data == SC_CAPS) begin
              tog_caps = 1'b1;
            end else begin
              addr_n  = bus.sc_data;
              wait_n  = 2'd0;
              state_n = ST_LOOK;
            end
          end
        end
      end
      ST_BRK: begin
        ready = 1'b1;
        if (bus.sc_valid) begin
          if (bus.sc_data == SC_LSHIFT) clr_l = 1'b1;
          if (bus.sc_data == SC_RSHIFT) clr_r = 1'b1;
`ifdef KBD_ASCII_CTRL_REPEAT_FILTER_EN
          if (bus.sc_data == last_make) last_make_n = 8'h00;
`endif
          state_n = ST_IDLE;
        end
      end
      ST_EXT: begin
        ready = 1'b1;
        if (bus.sc_valid) begin
          state_n = (bus.sc_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        end
      end
      ST_EXT_BRK: begin
        ready = 1'b1;
        if (bus.sc_valid) state_n = ST_IDLE;
      end
      ST_LOOK: begin
        if (wait_q == LOOK_LAST) begin
          data_n  = bus.rom_data;
          state_n = ST_EMIT;
        end else begin
          wait_n = wait_q + 2'd1;
        end
      end
      ST_EMIT: begin
        // 00 in the table marks a non-printable key
        emit    = (data_q != 8'h00);
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state, lookup registers and character output
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= 8'h00;
      wait_q      <= 2'd0;
      data_q      <= 8'h00;
      ascii       <= 8'h00;
      ascii_valid <= 1'b0;
      key_cnt     <= '0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      wait_q      <= wait_n;
      data_q      <= data_n;
      ascii_valid <= emit;
      if (emit) begin
        ascii   <= data_q;
        key_cnt <= key_cnt + CNT_W'(1);
      end
    end
  end

`ifdef KBD_ASCII_CTRL_REPEAT_FILTER_EN
  // last accepted non-modifier make code
  always_ff @(posedge clk) begin
    if (rst) last_make <= 8'h00;
    else     last_make <= last_make_n;
  end
`endif

endmodule
